// File: rtl/edge_tick_bank_if.sv
// Level inputs, mode/clear controls and tick/count outputs of edge_tick_bank.
// The slave side is the bank; the master side is whatever drives the pins.
interface edge_tick_bank_if #(
    parameter int N  = 4,
    parameter int CW = 8
);
    logic [N-1:0]  level;
    logic [1:0]    mode;
    logic          cnt_clr;
    logic [N-1:0]  tick_mealy;
    logic [N-1:0]  tick_moore;
    logic [N-1:0]  filt;
    logic [CW-1:0] edge_cnt;

    modport master (
        output level, mode, cnt_clr,
        input  tick_mealy, tick_moore, filt, edge_cnt
    );

    modport slave (
        input  level, mode, cnt_clr,
        output tick_mealy, tick_moore, filt, edge_cnt
    );
endinterface

// File: rtl/edge_tick_bank.sv
// N-channel debounced edge detector with per-channel Mealy/Moore ticks and a
// saturating count of qualified edges across all channels.
module edge_tick_bank #(
    parameter int N      = 4,
    parameter int STABLE = 3,
    parameter int CW     = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    edge_tick_bank_if.slave bus
);
    // state    | meaning
    // LOW      | debounced level 0, no tick
    // HIGH     | debounced level 1, no tick
    // TICK_HI  | qualified edge into level 1 last cycle, tick_moore high
    // TICK_LO  | qualified edge into level 0 last cycle, tick_moore high
    typedef enum logic [1:0] {LOW, HIGH, TICK_HI, TICK_LO} state_e;

    localparam int CNTW = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam int PW   = $clog2(N + 1);
    localparam logic [CNTW-1:0] C_LIM = CNTW'(STABLE - 1);

    logic [N-1:0]     f_q, f_d;
    logic [N-1:0]     qual;
    logic [N-1:0]     moore;
    logic [CNTW-1:0]  c_q [N];
    logic [CNTW-1:0]  c_d [N];
    state_e           s_q [N];
    state_e           s_d [N];
    logic [CW-1:0]    edge_cnt_q, edge_cnt_d;
    logic [PW-1:0]    pop;
    logic [CW+PW-1:0] sum;

    // A change is accepted on the STABLE-th consecutive differing sample;
    // mode only gates qualification, so debouncing continues when disabled.
    always_comb begin
        f_d  = f_q;
        qual = '0;
        for (int i = 0; i < N; i++) begin
            c_d[i] = '0;
            if (bus.level[i] != f_q[i]) begin
                if (c_q[i] == C_LIM) begin
                    f_d[i] = bus.level[i];
                    case (bus.mode)
                        2'b00:   qual[i] = bus.level[i];
                        2'b01:   qual[i] = !bus.level[i];
                        2'b10:   qual[i] = 1'b1;
                        default: qual[i] = 1'b0;
                    endcase
                end else begin
                    c_d[i] = c_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            f_q <= '0;
            for (int i = 0; i < N; i++) c_q[i] <= '0;
        end else begin
            f_q <= f_d;
            for (int i = 0; i < N; i++) c_q[i] <= c_d[i];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N; i++) begin
            if (reset_i) s_q[i] <= LOW;
            else         s_q[i] <= s_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (f_d[i]) s_d[i] = qual[i] ? TICK_HI : HIGH;
            else        s_d[i] = qual[i] ? TICK_LO : LOW;
        end
    end

    always_comb begin
        moore = '0;
        for (int i = 0; i < N; i++) begin
            moore[i] = (s_q[i] == TICK_HI) || (s_q[i] == TICK_LO);
        end
    end

    // Sum in a widened adder so any carry past CW bits clamps to all-ones.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) pop = pop + PW'(qual[i]);
        sum = {{PW{1'b0}}, edge_cnt_q} + {{CW{1'b0}}, pop};
        if (bus.cnt_clr)         edge_cnt_d = '0;
        else if (|sum[CW+PW-1:CW]) edge_cnt_d = '1;
        else                     edge_cnt_d = sum[CW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) edge_cnt_q <= '0;
        else         edge_cnt_q <= edge_cnt_d;
    end

    assign bus.tick_mealy = qual & {N{!reset_i}};
    assign bus.tick_moore = moore;
    assign bus.filt       = f_q;
    assign bus.edge_cnt   = edge_cnt_q;
endmodule

// File: tb/tb_edge_tick_bank.sv
// Drives two edge_tick_bank instances (STABLE=3/CW=8 and STABLE=1/CW=3) with
// shared directed and random stimulus, checking each against a reference model.
module tb_edge_tick_bank;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] lvl;
    logic [1:0] md;
    logic       clr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0]      fa, ma, fb, mb;
    logic [3:0][7:0] runa, runb;
    int              ca, cb;

    edge_tick_bank_if #(.N(4), .CW(8)) ifa ();
    edge_tick_bank_if #(.N(4), .CW(3)) ifb ();

    assign ifa.level = lvl;  assign ifa.mode = md;  assign ifa.cnt_clr = clr;
    assign ifb.level = lvl;  assign ifb.mode = md;  assign ifb.cnt_clr = clr;

    edge_tick_bank #(.N(4), .STABLE(3), .CW(8)) dut_a (.clk_i(clk), .reset_i(rst), .bus(ifa));
    edge_tick_bank #(.N(4), .STABLE(1), .CW(3)) dut_b (.clk_i(clk), .reset_i(rst), .bus(ifb));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // run[i] = number of consecutive past samples differing from the filtered level
    task automatic model_step(input int stable, input int cw,
                              inout logic [3:0] f, inout logic [3:0][7:0] run,
                              inout int cnt, inout logic [3:0] mo,
                              output logic [3:0] mealy);
        logic [3:0] q;
        int         pop;
        int         cmax;
        logic       diff, acc;
        q    = '0;
        pop  = 0;
        cmax = (1 << cw) - 1;
        for (int i = 0; i < 4; i++) begin
            diff = (lvl[i] != f[i]);
            acc  = diff && (int'(run[i]) == stable - 1);
            case (md)
                2'b00:   q[i] = acc && lvl[i];
                2'b01:   q[i] = acc && !lvl[i];
                2'b10:   q[i] = acc;
                default: q[i] = 1'b0;
            endcase
            pop += int'(q[i]);
            if (acc) begin
                f[i]   = lvl[i];
                run[i] = 8'd0;
            end else if (diff) begin
                run[i] = run[i] + 8'd1;
            end else begin
                run[i] = 8'd0;
            end
        end
        mealy = rst ? 4'b0 : q;
        if (rst) begin
            f = '0; run = '0; cnt = 0; mo = '0;
        end else begin
            mo = q;
            if (clr) cnt = 0;
            else     cnt = (cnt + pop > cmax) ? cmax : cnt + pop;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the next rising edge.
    task automatic cycle(input logic [3:0] l, input logic [1:0] m, input logic c, input logic r);
        logic [3:0] ea, eb;
        lvl = l; md = m; clr = c; rst = r;
        #1;
        model_step(3, 8, fa, runa, ca, ma, ea);
        model_step(1, 3, fb, runb, cb, mb, eb);
        check_val("a.mealy", 32'(ifa.tick_mealy), 32'(ea));
        check_val("b.mealy", 32'(ifb.tick_mealy), 32'(eb));
        @(posedge clk);
        #1;
        check_val("a.filt",  32'(ifa.filt),       32'(fa));
        check_val("a.moore", 32'(ifa.tick_moore), 32'(ma));
        check_val("a.cnt",   32'(ifa.edge_cnt),   32'(ca));
        check_val("b.filt",  32'(ifb.filt),       32'(fb));
        check_val("b.moore", 32'(ifb.tick_moore), 32'(mb));
        check_val("b.cnt",   32'(ifb.edge_cnt),   32'(cb));
    endtask

    initial begin
        logic [3:0] l;
        logic [1:0] m;
        fa = '0; ma = '0; fb = '0; mb = '0; runa = '0; runb = '0; ca = 0; cb = 0;
        lvl = '0; md = 2'b00; clr = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        cycle(4'b0000, 2'b00, 1'b0, 1'b1);
        cycle(4'b0000, 2'b00, 1'b0, 1'b1);

        // rising edge on ch0 held; then a 2-sample glitch on ch1
        repeat (5) cycle(4'b0001, 2'b00, 1'b0, 1'b0);
        check_val("s1.a_cnt",  32'(ifa.edge_cnt), 32'd1);
        check_val("s1.a_filt", 32'(ifa.filt),     32'b0001);
        repeat (2) cycle(4'b0011, 2'b00, 1'b0, 1'b0);
        repeat (4) cycle(4'b0001, 2'b00, 1'b0, 1'b0);
        check_val("s2.a_cnt",  32'(ifa.edge_cnt), 32'd1);

        // both-edge mode, ch2 toggling every cycle
        cycle(4'b0001, 2'b10, 1'b1, 1'b0);
        l = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            l[2] = ~l[2];
            cycle(l, 2'b10, 1'b0, 1'b0);
        end
        check_val("s3.b_sat", 32'(ifb.edge_cnt), 32'd7);
        cycle(l, 2'b10, 1'b1, 1'b0);
        check_val("s3.b_clr", 32'(ifb.edge_cnt), 32'd0);

        // all channels fall together: falling mode, then disabled
        repeat (4) cycle(4'b1111, 2'b10, 1'b0, 1'b0);
        repeat (4) cycle(4'b0000, 2'b01, 1'b0, 1'b0);
        repeat (4) cycle(4'b1111, 2'b11, 1'b0, 1'b0);
        repeat (4) cycle(4'b0000, 2'b11, 1'b0, 1'b0);
        check_val("s4.a_filt", 32'(ifa.filt), 32'b0000);

        // reset one cycle into ch3 debounce, level kept high
        cycle(4'b1000, 2'b00, 1'b0, 1'b0);
        cycle(4'b1000, 2'b00, 1'b0, 1'b1);
        repeat (5) cycle(4'b1000, 2'b00, 1'b0, 1'b0);

        // cnt_clr together with reset
        cycle(4'b0000, 2'b10, 1'b1, 1'b1);

        for (int k = 0; k < 800; k++) begin
            l = lvl ^ 4'($urandom & $urandom & $urandom);
            m = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : md;
            cycle(l, m, $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/edge_tick_bank.md
# edge_tick_bank

Parametrised multi-channel edge detector: each of N asynchronous-origin level inputs is debounced, then produces one-cycle Moore and Mealy tick pulses on rising, falling or both edges per a shared mode select. A saturating counter tallies qualified edges across all channels. Sits between raw switch/sensor pins and control logic, replacing single-channel Moore/Mealy tick generators.

## Interface
- N, default 4, number of channels (1..32)
- STABLE, default 3, consecutive differing samples required to accept a level change (>=1)
- CW, default 8, width of the edge counter
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- level  in  N  raw per-channel level (already synchronised upstream)
- mode  in  2  00 rising, 01 falling, 10 both, 11 disabled; shared by all channels
- cnt_clr  in  1  synchronous clear of edge_cnt
- tick_mealy  out  N  combinational per-channel tick, same cycle as the accepted change
- tick_moore  out  N  registered per-channel tick, one cycle after tick_mealy
- filt  out  N  debounced level per channel
- edge_cnt  out  CW  saturating count of qualified edges

## Operation
- Per channel i: debounced level f[i], counter c[i] (width clog2(STABLE), min 1), Moore state s[i].
- Debounce: if level[i]==f[i], c<=0. Else if c==STABLE-1, f<=level[i], c<=0 (change accepted). Else c<=c+1.
- STABLE=1: f follows level with one-cycle delay; every input toggle accepted.
- accept[i] = (level[i]!=f[i]) && (c[i]==STABLE-1); direction = level[i] (1 rise, 0 fall).
- q[i] (qualified) = accept[i] && ((mode==00 && rise) || (mode==01 && fall) || mode==10); mode 11 gives q=0, debounce still runs.
- tick_mealy[i] = q[i] && !reset.
- Moore FSM states: LOW, HIGH, TICK_HI, TICK_LO. Next state = f_next ? (q ? TICK_HI : HIGH) : (q ? TICK_LO : LOW). tick_moore[i]=1 iff s in {TICK_HI, TICK_LO}. TICK states last one cycle unless another qualified edge follows immediately (STABLE=1 only).
- edge_cnt: each cycle adds popcount(q); result saturates at 2^CW-1 (never wraps). cnt_clr loads 0 and discards that cycle's edges.
- mode changes take effect combinationally on the same cycle; a change mid-debounce does not reset c.

## Timing
- Reset values: f=0, c=0, s=LOW, edge_cnt=0, tick_mealy=0, tick_moore=0, filt=0.
- Latency: level change sampled at edge k and held -> tick_mealy high during cycle ending at edge k+STABLE-1; f and tick_moore update at that edge; tick_moore high for the following cycle; edge_cnt updated at the same edge.
- Glitch shorter than STABLE samples: c returns to 0, no tick, f unchanged.
- Level high at reset release: treated as rising edge from f=0 after STABLE samples.
- Reset mid-debounce or during a TICK state: cleared next edge; pending edge lost; tick_moore drops after that edge.
- Simultaneous edges on multiple channels: all ticks assert; edge_cnt adds full popcount, clamped at max.
- cnt_clr and reset both high: reset wins (same result).

## Test plan
- N=4, STABLE=3, mode=00: level[0] 0->1 held 5 cycles -> tick_mealy[0] one cycle, 3rd sample after change; tick_moore[0] next cycle; edge_cnt=1; filt[0]=1.
- level[1] high for 2 cycles then low -> no ticks, filt[1]=0, edge_cnt unchanged.
- mode=10, STABLE=1, level[2] toggling every cycle for 8 cycles -> tick_mealy[2] and tick_moore[2] high continuously (Moore lagging 1), edge_cnt=8.
- mode=01 then 11: channels 0..3 fall together -> edge_cnt +4 under 01; under 11 no ticks, filt still updates.
- CW=3: 10 qualified edges -> edge_cnt saturates at 7; cnt_clr -> 0 next cycle.
- Reset asserted 1 cycle after level[3] rises (mid-debounce) while level held high -> all outputs 0; rising tick occurs STABLE samples after reset release.
